uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver: idle-high, 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Companion to the team's UART transmitter, at the same bit period (2604 clk per bit, 25 MHz / 9600 baud).
- Sits between the async rxd pin and the core logic.
- Delivers one byte per frame with a single-cycle valid strobe, and flags framing errors.

Parameters:
- CLKS_PER_BIT, 2604: clk cycles per bit. Legal range 4..4095; fits a 12-bit counter.
- HALF_BIT, CLKS_PER_BIT/2 (1302): delay from start-edge detection to the start-bit mid-point sample.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly received byte. Holds until the next good frame.
- rx_valid  output  1  one-cycle pulse; data is new on that cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - data=8'h00, rx_valid=0, frame_err=0, busy=0.
  - Both synchronizer flops preset to 1, so no false start on release.
- Input sync: rxd passes through 2 flops (rxs). All decisions use rxs only.
- Counter: 12-bit. Cleared on every state change. Otherwise increments each clk while not IDLE/BREAK.
- IDLE:
  - rxs==0 -> START, counter=0.
- START:
  - At counter==HALF_BIT-1, sample rxs.
  - Sample 0 -> DATA, bit index=0.
  - Sample 1 -> glitch; return to IDLE with no outputs.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rxs into bit[index] (LSB first) and clear counter.
  - After index 7 is sampled -> STOP.
- STOP, at counter==CLKS_PER_BIT-1, sample rxs:
  - Sample 1 -> data<=shift reg, rx_valid=1 for one cycle, go to IDLE.
  - Sample 0 -> frame_err=1 for one cycle, data unchanged, go to BREAK.
- BREAK: wait for rxs==1, then IDLE. This prevents a held-low line from retriggering.
- Latency: let E0 be the first clk edge at which the pin is low. rx_valid is high in the cycle following edge E0+2+HALF_BIT+9*CLKS_PER_BIT (24740 for the defaults).
- Timing between frames:
  - A new start edge may arrive immediately after the stop sample; IDLE accepts it on the next cycle.
  - Back-to-back frames must not drop bytes.
- rx_valid and frame_err are never high together.
- Async reset mid-frame aborts immediately. The partial byte is discarded, with no pulses.
- Invalid state encoding recovers to IDLE.

Decomposition:
- Package uart_pkg:
  - state encoding: IDLE, START, DATA, STOP, BREAK.
  - CLKS_PER_BIT default (2604), shared with the transmitter.
  - DATA_BITS=8.
- Sub-module sync_2ff: 2-flop synchronizer with async active-low reset to 1, reusable elsewhere.
- FSM, counter and shift register all stay in uart_rx.

Test Plan:
- Byte 8'hA5, CLKS_PER_BIT=16 bench override, ideal timing:
  - rx_valid pulses once, 1 cycle wide, data=8'hA5.
  - Latency matches E0+2+8+144.
  - frame_err stays 0.
- Back-to-back 8'h00, 8'hFF, 8'h3C with no idle gap: exactly three rx_valid pulses, in that order.
- Start glitch, rxd low 3 cycles then high (N=16): busy rises then returns to 0, with no rx_valid or frame_err.
- Stop bit forced low on 8'h55:
  - frame_err pulses once; data keeps its prior value.
  - busy stays high until rxd returns high. A following good 8'h81 is received.
- Reset asserted mid-DATA of 8'hC3:
  - All outputs return to reset values.
  - After release, a fresh 8'h12 frame is received correctly.
- Default parameters, rxd period skewed ±2% on 8'h96: data=8'h96, rx_valid once.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 2604;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer; both flops preset high so an idle line stays idle out of reset
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset)
        if (!reset) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, single-cycle valid and framing-error strobes
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT,
    parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam logic [11:0] FULL_END = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HALF_END = 12'(HALF_BIT - 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    rx_state_t state;
    logic [11:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shreg;
    logic rxs;

    sync_2ff u_sync (.clk(clk), .reset(reset), .d(rxd), .q(rxs));

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    cnt <= cnt == HALF_END ? '0 : cnt + 12'd1;
                    idx <= '0;
                    if (cnt == HALF_END) state <= rxs ? IDLE : DATA;
                end
                DATA: begin
                    cnt <= cnt == FULL_END ? '0 : cnt + 12'd1;
                    if (cnt == FULL_END) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == LAST_BIT) state <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt == FULL_END ? '0 : cnt + 12'd1;
                    if (cnt == FULL_END) begin
                        state     <= rxs ? IDLE : BREAK;
                        rx_valid  <= rxs;
                        frame_err <= !rxs;
                        if (rxs) data <= shreg;
                    end
                end
                BREAK: begin
                    // Held-low line must go high before a new start edge is accepted
                    cnt <= '0;
                    if (rxs) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
